// File: rtl/scan_mux.sv
// scan_mux: registered N-channel data multiplexer with automatic scan and
// manual select.
//
// state  | meaning
// IDLE   | en=0; sel/out/out_ch hold, dwell count cleared, valid=0, wrap=0
// SCAN   | en=1, mode=0; sel advances every DWELL cycles, cycling channels
// MANUAL | en=1, mode=1; sel loads sel_in when it names a real channel
//
// Parameters: NCH channels (2..16), DW data width, DWELL cycles per channel
// (1..256), SW select width.
// Ports:
//   ck      clock, rising edge
//   rst     asynchronous active-high reset
//   vdd     supply rail; every output high level follows it
//   en      block enable
//   mode    0 = automatic scan, 1 = manual select
//   sel_in  manual channel index
//   d       flattened channel data, channel k at d[k*DW +: DW]
//   mask    (SCAN_MUX_SKIP_EN only) channels taking part in the scan
//   out     data captured from channel sel on the previous enabled edge
//   out_ch  channel index out was captured from
//   sel     current channel pointer
//   valid   out/out_ch hold meaningful data
//   wrap    one-cycle pulse after the scan wraps around
// Build option: define SCAN_MUX_SKIP_EN to add mask and skip masked channels.
module scan_mux #(
  parameter int NCH   = 8,
  parameter int DW    = 8,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(NCH)
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              vdd,
  input  logic              en,
  input  logic              mode,
  input  logic [SW-1:0]     sel_in,
  input  logic [NCH*DW-1:0] d,
`ifdef SCAN_MUX_SKIP_EN
  input  logic [NCH-1:0]    mask,
`endif
  output logic [DW-1:0]     out,
  output logic [SW-1:0]     out_ch,
  output logic [SW-1:0]     sel,
  output logic              valid,
  output logic              wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW:0]   NCH_X    = (SW + 1)'(NCH);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_MANUAL} state_t;

  state_t          st, st_nxt;
  logic [SW-1:0]   sel_q, sel_nxt, och_q, adv_ch;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [DW-1:0]   out_q, dsel;
  logic            ok_q, ok_nxt, wrap_q, wrap_nxt, adv_wrap, scan_hold;

  always_comb begin
    dsel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_q == SW'(k)) dsel = d[k*DW +: DW];
    end
  end

`ifdef SCAN_MUX_SKIP_EN
  logic [SW-1:0] first_any, first_after;
  logic          any_set, after_set;

  // Descending walk so the lowest qualifying channel is the one kept.
  always_comb begin
    first_any   = '0;
    first_after = '0;
    any_set     = 1'b0;
    after_set   = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        any_set   = 1'b1;
        first_any = SW'(k);
        if (SW'(k) > sel_q) begin
          after_set   = 1'b1;
          first_after = SW'(k);
        end
      end
    end
    adv_ch    = after_set ? first_after : first_any;
    // No masked channel above sel means the new sel is <= the old one.
    adv_wrap  = any_set & ~after_set;
    scan_hold = ~any_set;
  end
`else
  always_comb begin
    adv_wrap  = (sel_q == SW'(NCH - 1));
    adv_ch    = adv_wrap ? '0 : sel_q + 1'b1;
    scan_hold = 1'b0;
  end
`endif

  // Edge behaviour follows the state being entered, so the first enabled
  // edge already counts dwell / loads sel_in.
  always_comb begin
    st_nxt   = ST_IDLE;
    sel_nxt  = sel_q;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    ok_nxt   = 1'b0;
    if (en) st_nxt = mode ? ST_MANUAL : ST_SCAN;
    case (st_nxt)
      ST_SCAN: begin
        ok_nxt = ~scan_hold;
        if (!scan_hold) begin
          if (cnt_q == CNT_LAST) begin
            sel_nxt  = adv_ch;
            wrap_nxt = adv_wrap;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      ST_MANUAL: begin
        ok_nxt = 1'b1;
        if ({1'b0, sel_in} < NCH_X) sel_nxt = sel_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      st     <= ST_IDLE;
      sel_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ok_q   <= 1'b0;
      out_q  <= '0;
      och_q  <= '0;
    end else begin
      st     <= st_nxt;
      sel_q  <= sel_nxt;
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
      ok_q   <= ok_nxt;
      if (en) begin
        out_q <= dsel;
        och_q <= sel_q;
      end
    end
  end

  assign out    = out_q & {DW{vdd}};
  assign out_ch = och_q & {SW{vdd}};
  assign sel    = sel_q & {SW{vdd}};
  assign valid  = vdd & (st != ST_IDLE) & ok_q;
  assign wrap   = vdd & wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

  localparam int NCH = 8;
  localparam int DW  = 8;
  localparam int SW  = 4;

  logic            ck = 1'b0;
  logic            rst, vdd, en, mode;
  logic [SW-1:0]   sel_in;
  logic [NCH*DW-1:0] d;
`ifdef SCAN_MUX_SKIP_EN
  logic [NCH-1:0]  mask;
`endif
  logic [DW-1:0]   out0, out1;
  logic [SW-1:0]   och0, och1, sel0, sel1;
  logic            valid0, valid1, wrap0, wrap1;

  int total = 0;
  int bad   = 0;

  always #5 ck = ~ck;

  scan_mux #(.NCH(NCH), .DW(DW), .DWELL(2), .SW(SW)) u0 (
    .ck(ck), .rst(rst), .vdd(vdd), .en(en), .mode(mode), .sel_in(sel_in), .d(d),
`ifdef SCAN_MUX_SKIP_EN
    .mask(mask),
`endif
    .out(out0), .out_ch(och0), .sel(sel0), .valid(valid0), .wrap(wrap0));

  scan_mux #(.NCH(NCH), .DW(DW), .DWELL(1), .SW(SW)) u1 (
    .ck(ck), .rst(rst), .vdd(vdd), .en(en), .mode(mode), .sel_in(sel_in), .d(d),
`ifdef SCAN_MUX_SKIP_EN
    .mask(mask),
`endif
    .out(out1), .out_ch(och1), .sel(sel1), .valid(valid1), .wrap(wrap1));

  // Reference model: one entry per instance (0: dwell 2, 1: dwell 1).
  int m_sel[2], m_cnt[2], m_out[2], m_och[2], m_val[2], m_wrap[2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_sel[u] = 0; m_cnt[u] = 0; m_out[u] = 0;
      m_och[u] = 0; m_val[u] = 0; m_wrap[u] = 0;
    end
  endtask

  task automatic model_edge();
    int dw;
    for (int u = 0; u < 2; u++) begin
      dw = (u == 0) ? 2 : 1;
      if (en) begin
        m_out[u]  = int'(d[m_sel[u]*DW +: DW]);
        m_och[u]  = m_sel[u];
        m_val[u]  = 1;
        m_wrap[u] = 0;
        if (!mode) begin
          if (m_cnt[u] == dw - 1) begin
            m_wrap[u] = (m_sel[u] == NCH - 1) ? 1 : 0;
            m_sel[u]  = (m_sel[u] + 1) % NCH;
            m_cnt[u]  = 0;
          end else begin
            m_cnt[u] = m_cnt[u] + 1;
          end
        end else begin
          if (int'(sel_in) < NCH) m_sel[u] = int'(sel_in);
          m_cnt[u] = 0;
        end
      end else begin
        m_val[u] = 0; m_wrap[u] = 0; m_cnt[u] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; model follows the same inputs; sample 1 time unit later.
  task automatic step();
    @(posedge ck);
    model_edge();
    #1;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit       en;
    bit       mode;
    logic [3:0] sel_in;
    int       eo;
    int       eoch;
    int       esel;
    int       ev;
    int       ew;
  } vec_t;

  vec_t tbl[20];

  initial begin
    for (int i = 1; i <= 17; i++) begin
      tbl[i-1].en     = 1'b1;
      tbl[i-1].mode   = 1'b0;
      tbl[i-1].sel_in = 4'd0;
      tbl[i-1].eoch   = ((i - 1) / 2) % NCH;
      tbl[i-1].eo     = 'h10 + tbl[i-1].eoch;
      tbl[i-1].esel   = (i / 2) % NCH;
      tbl[i-1].ev     = 1;
      tbl[i-1].ew     = (i == 16) ? 1 : 0;
    end
    tbl[17] = '{1'b1, 1'b1, 4'd5, 'h10, 0, 5, 1, 0};
    tbl[18] = '{1'b1, 1'b1, 4'd9, 'h15, 5, 5, 1, 0};
    tbl[19] = '{1'b1, 1'b1, 4'd9, 'h15, 5, 5, 1, 0};

    vdd = 1'b1; en = 1'b0; mode = 1'b0; sel_in = '0;
    for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'('h10 + k);
`ifdef SCAN_MUX_SKIP_EN
    mask = '1;
`endif
    model_reset();

    // Reset state, checked before any clock edge.
    rst = 1'b1;
    #3;
    chk("rst_out", int'(out0), 0);
    chk("rst_och", int'(och0), 0);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_wrap", int'(wrap0), 0);
    @(negedge ck);
    rst = 1'b0;

    // Full scan cycle followed by manual select with a legal then illegal index.
    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; sel_in = tbl[i].sel_in;
      step();
      chk("tbl_out", int'(out0), tbl[i].eo);
      chk("tbl_och", int'(och0), tbl[i].eoch);
      chk("tbl_sel", int'(sel0), tbl[i].esel);
      chk("tbl_valid", int'(valid0), tbl[i].ev);
      chk("tbl_wrap", int'(wrap0), tbl[i].ew);
    end

    // Disable mid-dwell at channel 3, then resume with a full dwell.
    pulse_rst();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pause_sel_before", int'(sel0), 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_valid", int'(valid0), 0);
      chk("pause_sel", int'(sel0), 3);
    end
    en = 1'b1;
    step();
    chk("resume_sel_a", int'(sel0), 3);
    chk("resume_valid", int'(valid0), 1);
    step();
    chk("resume_sel_b", int'(sel0), 4);
    chk("resume_och_b", int'(och0), 3);
    step();
    chk("resume_out_c", int'(out0), 'h14);

    // Asynchronous reset between edges while sitting on channel 6.
    pulse_rst();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("arst_sel_before", int'(sel0), 6);
    #1 rst = 1'b1;
    #1;
    chk("arst_out", int'(out0), 0);
    chk("arst_och", int'(och0), 0);
    chk("arst_sel", int'(sel0), 0);
    chk("arst_valid", int'(valid0), 0);
    chk("arst_wrap", int'(wrap0), 0);
    #1 rst = 1'b0;
    model_reset();
    step();
    chk("arst_rel_out", int'(out0), 'h10);
    chk("arst_rel_valid", int'(valid0), 1);
    chk("arst_rel_och", int'(och0), 0);

`ifdef SCAN_MUX_SKIP_EN
    // Masked scan visits 0,2,7,0 and wraps on 7->0; empty mask holds.
    pulse_rst();
    mask = 8'b1000_0101;
    en = 1'b1; mode = 1'b0;
    step(); chk("skip_sel1", int'(sel0), 0);
    step(); chk("skip_sel2", int'(sel0), 2);
    step(); step(); chk("skip_sel4", int'(sel0), 7);
    chk("skip_nowrap4", int'(wrap0), 0);
    step(); step(); chk("skip_sel6", int'(sel0), 0);
    chk("skip_wrap6", int'(wrap0), 1);
    step(); chk("skip_wrap7", int'(wrap0), 0);
    mask = '0;
    step(); step();
    chk("skip_empty_sel", int'(sel0), 0);
    chk("skip_empty_valid", int'(valid0), 0);
    mask = '1;
`endif

    // Randomised run against the model, both dwell settings.
    pulse_rst();
    mode = 1'b0;
    for (int n = 0; n < 800; n++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 12 == 0) mode = ~mode;
      sel_in = SW'($urandom % 16);
      d = {$urandom, $urandom};
      if ($urandom % 150 == 0) pulse_rst();
      step();
      chk("rnd_out", int'(out0), m_out[0]);
      chk("rnd_och", int'(och0), m_och[0]);
      chk("rnd_sel", int'(sel0), m_sel[0]);
      chk("rnd_valid", int'(valid0), m_val[0]);
      chk("rnd_wrap", int'(wrap0), m_wrap[0]);
      chk("rnd1_out", int'(out1), m_out[1]);
      chk("rnd1_sel", int'(sel1), m_sel[1]);
      chk("rnd1_valid", int'(valid1), m_val[1]);
      chk("rnd1_wrap", int'(wrap1), m_wrap[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter NCH, default 8: number of input channels, legal range 2..16.
REQ-002 Parameter DW, default 8: data width per channel.
REQ-003 Parameter DWELL, default 4: clock cycles spent on each channel in scan mode, legal range 1..256.
REQ-004 Parameter SW, default $clog2(NCH): select width.
REQ-005 CK  input  1  clock; the block uses one clock and all state updates on the rising edge of CK.
REQ-006 RST  input  1  reset; asynchronous, active-high.
REQ-007 VDD  input  1  supply rail; every output logic 1 drives the VDD level and every logic 0 drives 0.
REQ-008 EN  input  1  block enable.
REQ-009 MODE  input  1  0 = automatic scan, 1 = manual select.
REQ-010 SEL_IN  input  SW  manual channel index.
REQ-011 D  input  NCH*DW  channel data, flattened; channel k occupies D[k*DW +: DW].
REQ-012 OUT  output  DW  registered selected data.
REQ-013 OUT_CH  output  SW  index of the channel that OUT was sampled from.
REQ-014 SEL  output  SW  current channel pointer.
REQ-015 VALID  output  1  OUT/OUT_CH hold meaningful data.
REQ-016 WRAP  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-017 States SHALL be IDLE, SCAN and MANUAL: EN=0 -> IDLE; EN=1 with MODE=0 -> SCAN; EN=1 with MODE=1 -> MANUAL; the state is re-evaluated every cycle.
REQ-018 IDLE: SEL, OUT and OUT_CH SHALL hold; the dwell counter SHALL clear; VALID=0 and WRAP=0 on the next edge.
REQ-019 SCAN: the dwell counter SHALL count 0..DWELL-1; when the count equals DWELL-1, SEL SHALL advance to the next channel and the count SHALL return to 0.
REQ-020 SCAN wrap: an advance from NCH-1 to 0 SHALL assert WRAP for exactly the cycle following the edge on which SEL changes.
REQ-021 MANUAL: SEL SHALL load SEL_IN on each edge if SEL_IN<NCH, otherwise SEL SHALL hold; the dwell counter SHALL clear; WRAP=0.
REQ-022 Output path: on every edge with EN=1, OUT SHALL capture D[SEL] and OUT_CH SHALL capture SEL (the pre-edge SEL value), giving a latency of 1 cycle from SEL to OUT.
REQ-023 VALID SHALL equal 1 on the cycle after any edge at which EN=1 and the captured channel index is legal, and 0 otherwise.
REQ-024 MODE switch SCAN->MANUAL mid-dwell SHALL abandon the dwell count; MANUAL->SCAN SHALL resume scanning from the current SEL with the count at 0.
REQ-025 DWELL=1 SHALL advance SEL on every enabled SCAN edge.

Reset
REQ-026 While RST=1, regardless of CK, the following SHALL hold: SEL=0, dwell count=0, OUT=0, OUT_CH=0, VALID=0, WRAP=0, state IDLE.
REQ-027 RST asserted mid-dwell or mid-wrap SHALL discard all progress; the first enabled edge after release SHALL capture channel 0.

Configuration
REQ-028 Macro SCAN_MUX_SKIP_EN: when it is defined, an extra input MASK [NCH-1:0] SHALL exist, and SCAN SHALL advance to the next channel in cyclic order whose MASK bit is 1.
REQ-029 With SCAN_MUX_SKIP_EN defined: WRAP SHALL pulse whenever the new SEL is less than or equal to the old SEL; if MASK is all zeros, SEL SHALL hold and VALID=0; MANUAL mode SHALL ignore MASK.
REQ-030 Without SCAN_MUX_SKIP_EN: the MASK port SHALL be absent and every channel SHALL be scanned.

Verification (NCH=8, DW=8, DWELL=2, D[k]=8'h10+k)
REQ-031 RST pulse, then EN=1, MODE=0 -> OUT sequence 10,10,11,11,...,17,17,10; WRAP high exactly once, in the cycle after SEL goes 7->0.
REQ-032 MODE=1, SEL_IN=5 then 9 -> OUT=15, OUT_CH=5 one cycle later; SEL stays 5 when SEL_IN=9.
REQ-033 Scan at SEL=3 with dwell count 1, then EN=0 for 3 cycles, then EN=1 -> VALID=0 while disabled; resumes at SEL=3 with a full dwell of 2 cycles.
REQ-034 RST asserted asynchronously between edges at SEL=6 -> all outputs 0 immediately; after release, OUT=10 with VALID=1.
REQ-035 SCAN_MUX_SKIP_EN defined, MASK=8'b1000_0101 -> SEL cycles 0,2,7,0 with WRAP on 7->0; MASK=0 -> SEL holds, VALID=0.
